key_cmd_scheduler: RTL and testbench

//  Collects one-cycle debounced key pulses from KEY_NUM debounce channels and queues them.

---
 rtl/key_cmd_scheduler_pkg.sv | 14 +
 rtl/key_cmd_scheduler_rr_pick.sv | 37 +++
 rtl/key_cmd_scheduler.sv | 122 ++++++++++++
 tb/tb_key_cmd_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_scheduler_pkg.sv
// Shared definitions for the key command scheduler.
//   state_t          : FSM state encoding (IDLE / ISSUE / WAIT)
//   TIMEOUT_DEFAULT  : default WAIT watchdog limit in clk cycles (1 s at 50 MHz)
package key_cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd49_999_999;

endpackage

// File: rtl/key_cmd_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Scans pend starting at rr_ptr+1, rr_ptr+2, ... (mod KEY_NUM) and returns the
// first set bit, so the most recently granted key has the lowest priority.
// Ports:
//   pend       in   KEY_NUM  pending-request vector
//   rr_ptr     in   IDW      index of the most recently granted key
//   grant_vld  out  1        at least one request pending
//   grant_idx  out  IDW      index of the chosen request (0 when none)
module key_cmd_scheduler_rr_pick #(
  parameter int KEY_NUM = 4,
  parameter int IDW     = $clog2(KEY_NUM)
) (
  input  logic [KEY_NUM-1:0] pend,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               grant_vld,
  output logic [IDW-1:0]     grant_idx
);

  always_comb begin
    int cand;
    logic [IDW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_vld = |pend;
    grant_idx = '0;
    // Walk from the farthest offset down to the nearest; the last hit
    // (smallest offset from rr_ptr) is the one that sticks.
    for (int off = KEY_NUM; off >= 1; off--) begin
      cand     = (int'(rr_ptr) + off) % KEY_NUM;
      cand_idx = IDW'(cand);
      if (pend[cand_idx]) begin
        grant_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Key command scheduler: queues one-cycle key pulses and issues them one at a
// time to the SPI operation controller via start/busy/done, with round-robin
// fairness and a WAIT-state watchdog.
// Ports:
//   clk          in   1        system clock
//   rst_n        in   1        synchronous active-low reset
//   key_flag     in   KEY_NUM  one-cycle debounced press pulses
//   op_busy      in   1        SPI controller busy level
//   op_done      in   1        SPI controller completion pulse
//   op_start     out  1        registered one-cycle start pulse
//   op_sel       out  IDW      index of the operation started (held until next start)
//   pend         out  KEY_NUM  pending-request vector
//   sched_busy   out  1        scheduler not idle
//   err_timeout  out  1        one-cycle pulse on watchdog expiry
module key_cmd_scheduler
  import key_cmd_scheduler_pkg::*;
#(
  parameter int          KEY_NUM     = 4,
  parameter logic [31:0] TIMEOUT_MAX = TIMEOUT_DEFAULT,
  localparam int         IDW         = $clog2(KEY_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_flag,
  input  logic               op_busy,
  input  logic               op_done,
  output logic               op_start,
  output logic [IDW-1:0]     op_sel,
  output logic [KEY_NUM-1:0] pend,
  output logic               sched_busy,
  output logic               err_timeout
);

  state_t               state_reg, state_next;
  logic [KEY_NUM-1:0]   pend_reg, pend_next;
  logic [IDW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]       op_sel_reg, op_sel_next;
  logic                 op_start_reg, op_start_next;
  logic                 err_reg, err_next;
  logic [31:0]          wd_cnt_reg, wd_cnt_next;
  logic                 grant_vld;
  logic [IDW-1:0]       grant_idx;

  key_cmd_scheduler_rr_pick #(
    .KEY_NUM (KEY_NUM),
    .IDW     (IDW)
  ) u_pick (
    .pend      (pend_reg),
    .rr_ptr    (rr_ptr_reg),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    rr_ptr_next   = rr_ptr_reg;
    op_sel_next   = op_sel_reg;
    op_start_next = 1'b0;
    err_next      = 1'b0;
    wd_cnt_next   = wd_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        // op_start is registered alongside the state change so it is high
        // exactly while the FSM sits in ISSUE.
        if (grant_vld && !op_busy) begin
          state_next    = ST_ISSUE;
          op_sel_next   = grant_idx;
          op_start_next = 1'b1;
        end
      end
      ST_ISSUE: begin
        pend_next[op_sel_reg] = 1'b0;
        rr_ptr_next           = op_sel_reg;
        wd_cnt_next           = '0;
        state_next            = ST_WAIT;
      end
      ST_WAIT: begin
        if (op_done) begin
          state_next = ST_IDLE;
        end else if (wd_cnt_reg >= TIMEOUT_MAX) begin
          // >= rather than == so the counter can never run past the limit
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wd_cnt_next = wd_cnt_reg + 32'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A new press wins over the grant clear, so a press landing in the
    // ISSUE cycle stays queued.
    pend_next = pend_next | key_flag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pend_reg     <= '0;
      rr_ptr_reg   <= IDW'(KEY_NUM - 1);
      op_sel_reg   <= '0;
      op_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      wd_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      rr_ptr_reg   <= rr_ptr_next;
      op_sel_reg   <= op_sel_next;
      op_start_reg <= op_start_next;
      err_reg      <= err_next;
      wd_cnt_reg   <= wd_cnt_next;
    end
  end

  assign op_start    = op_start_reg;
  assign op_sel      = op_sel_reg;
  assign pend        = pend_reg;
  assign sched_busy  = (state_reg != ST_IDLE);
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed testbench for key_cmd_scheduler (KEY_NUM=4, TIMEOUT_MAX=20).
// A per-cycle vector table covers reset, single press and busy stall; hand
// sequences cover fairness, merge/set-wins, watchdog and reset during WAIT.
module tb_key_cmd_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_flag;
  logic       op_busy;
  logic       op_done;
  logic       op_start;
  logic [1:0] op_sel;
  logic [3:0] pend;
  logic       sched_busy;
  logic       err_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  key_cmd_scheduler #(
    .KEY_NUM     (4),
    .TIMEOUT_MAX (32'd20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .op_busy     (op_busy),
    .op_done     (op_done),
    .op_start    (op_start),
    .op_sel      (op_sel),
    .pend        (pend),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] kf;
    logic       busy;
    logic       done;
    logic       x_start;
    logic [1:0] x_sel;
    logic [3:0] x_pend;
    logic       x_sb;
    logic       x_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] kf, logic b, logic d,
                              logic st, logic [1:0] sel, logic [3:0] p,
                              logic sb, logic er);
    vec_t v;
    v.rst_n = r; v.kf = kf; v.busy = b; v.done = d;
    v.x_start = st; v.x_sel = sel; v.x_pend = p; v.x_sb = sb; v.x_err = er;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic step(input logic r, input logic [3:0] kf, input logic b, input logic d);
    rst_n = r; key_flag = kf; op_busy = b; op_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  // Idle inputs until op_start shows; n = steps taken, -1 if it never came.
  task automatic wait_start(input logic b, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 4'b0000, b, 1'b0);
      if (op_start) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int t;
    logic [1:0] order3 [3];
    logic [1:0] order2 [2];

    rst_n = 1'b0; key_flag = 4'h0; op_busy = 1'b0; op_done = 1'b0;

    // ---- table: reset, single press, op_done, stall while busy ----
    //                  rst kf     bsy dn  start sel pend   sb err
    repeat (3) tbl.push_back(mk(0, 4'hF, 0, 0, 0, 2'd0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 0, 0, 2'd0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'h4, 0, 0, 0, 2'd0, 4'h4, 0, 0));  // pend at N+1
    tbl.push_back(mk(1, 4'h0, 0, 0, 1, 2'd2, 4'h4, 1, 0));  // start at N+2
    tbl.push_back(mk(1, 4'h0, 1, 0, 0, 2'd2, 4'h0, 1, 0));  // pend cleared N+3
    repeat (8) tbl.push_back(mk(1, 4'h0, 1, 0, 0, 2'd2, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 0, 2'd2, 4'h0, 0, 0));  // done -> IDLE
    tbl.push_back(mk(1, 4'h0, 0, 1, 0, 2'd2, 4'h0, 0, 0));  // done in IDLE ignored
    tbl.push_back(mk(1, 4'h1, 1, 0, 0, 2'd2, 4'h1, 0, 0));  // press, busy stalls
    tbl.push_back(mk(1, 4'h0, 1, 0, 0, 2'd2, 4'h1, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 0, 1, 2'd0, 4'h1, 1, 0));  // busy drops -> start
    tbl.push_back(mk(1, 4'h0, 0, 0, 0, 2'd0, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 0, 2'd0, 4'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].kf, tbl[i].busy, tbl[i].done);
      chk($sformatf("vec%0d.op_start", i), 32'(op_start), 32'(tbl[i].x_start));
      chk($sformatf("vec%0d.op_sel", i), 32'(op_sel), 32'(tbl[i].x_sel));
      chk($sformatf("vec%0d.pend", i), 32'(pend), 32'(tbl[i].x_pend));
      chk($sformatf("vec%0d.sched_busy", i), 32'(sched_busy), 32'(tbl[i].x_sb));
      chk($sformatf("vec%0d.err_timeout", i), 32'(err_timeout), 32'(tbl[i].x_err));
    end

    // ---- fairness: reset restores rr_ptr=3 ----
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'b1011, 1'b0, 1'b0);
    order3[0] = 2'd0; order3[1] = 2'd1; order3[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      wait_start(1'b0, n);
      chk($sformatf("rr3[%0d].latency", k), 32'(n), 32'd1);
      chk($sformatf("rr3[%0d].op_sel", k), 32'(op_sel), 32'(order3[k]));
      repeat (4) step(1'b1, 4'h0, 1'b1, 1'b0);
      step(1'b1, 4'h0, 1'b0, 1'b1);
    end
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    order2[0] = 2'd0; order2[1] = 2'd1;  // rr_ptr=3 -> key 0 first
    for (int k = 0; k < 2; k++) begin
      wait_start(1'b0, n);
      chk($sformatf("rr2[%0d].latency", k), 32'(n), 32'd1);
      chk($sformatf("rr2[%0d].op_sel", k), 32'(op_sel), 32'(order2[k]));
      repeat (4) step(1'b1, 4'h0, 1'b1, 1'b0);
      step(1'b1, 4'h0, 1'b0, 1'b1);
    end

    // ---- merge and set-wins on key 1 (rr_ptr now 1) ----
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    wait_start(1'b0, n);
    chk("merge.first_sel", 32'(op_sel), 32'd1);
    step(1'b1, 4'b0010, 1'b1, 1'b0);           // press during ISSUE
    chk("merge.set_wins_pend", 32'(pend), 32'h2);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("merge.pend_held", 32'(pend), 32'h2);
    step(1'b1, 4'h0, 1'b0, 1'b1);
    wait_start(1'b0, n);
    chk("merge.second_latency", 32'(n), 32'd1);
    chk("merge.second_sel", 32'(op_sel), 32'd1);
    step(1'b1, 4'h0, 1'b1, 1'b0);
    chk("merge.pend_cleared", 32'(pend), 32'h0);
    repeat (3) step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0);
      if (op_start) cnt++;
    end
    chk("merge.no_third_start", 32'(cnt), 32'd0);

    // ---- watchdog with op_busy held ----
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    wait_start(1'b0, n);
    chk("wd.start_sel", 32'(op_sel), 32'd2);
    step(1'b1, 4'h0, 1'b1, 1'b0);               // WAIT entry, wd_cnt=0
    chk("wd.in_wait", 32'(sched_busy), 32'd1);
    t = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, (i == 3) ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
      if (err_timeout) begin
        t = i;
        break;
      end
    end
    chk("wd.expiry_cycles", 32'(t), 32'd21);
    chk("wd.idle_after", 32'(sched_busy), 32'd0);
    chk("wd.pend_kept", 32'(pend), 32'h8);
    step(1'b1, 4'h0, 1'b1, 1'b0);
    chk("wd.err_one_cycle", 32'(err_timeout), 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h0, 1'b1, 1'b0);
      if (op_start) cnt++;
    end
    chk("wd.stalled_by_busy", 32'(cnt), 32'd0);
    wait_start(1'b0, n);
    chk("wd.reissue_latency", 32'(n), 32'd1);
    chk("wd.reissue_sel", 32'(op_sel), 32'd3);
    step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b1);

    // ---- reset during WAIT ----
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    wait_start(1'b0, n);
    chk("rst.start_sel", 32'(op_sel), 32'd0);
    step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("rst.pend_before", 32'(pend), 32'h2);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("rst.sched_busy", 32'(sched_busy), 32'd0);
    chk("rst.pend", 32'(pend), 32'h0);
    chk("rst.op_sel", 32'(op_sel), 32'd0);
    step(1'b1, 4'h0, 1'b0, 1'b1);               // stale op_done
    chk("rst.done_ignored", 32'(sched_busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0);
      if (op_start || err_timeout) cnt++;
    end
    chk("rst.quiet_after", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
